// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I/D-cache main-memory arbiter.
package mem_arbiter_pkg;

  // Transfer sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WDATA = 2'd2,
    ST_RDATA = 2'd3
  } state_e;

  // Owner encoding used on the grant output and in the round-robin state
  localparam logic GRANT_IC = 1'b0;
  localparam logic GRANT_DC = 1'b1;

  // Memory request direction
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Beat counter width: clog2 of the beat count, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin picker; the last-grant state is held by the caller.
module mem_arbiter_rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] valid,       // bit 0 = ICache, bit 1 = DCache
  input  logic       last_grant,
  output logic       grant,
  output logic [1:0] ready
);

  // Sole requester wins; on a tie the requester that did not win last time wins
  always_comb begin
    grant = last_grant;
    case (valid)
      2'b01:   grant = GRANT_IC;
      2'b10:   grant = GRANT_DC;
      2'b11:   grant = ~last_grant;
      default: grant = last_grant;
    endcase
    ready[0] = valid[0] & (grant == GRANT_IC);
    ready[1] = valid[1] & (grant == GRANT_DC);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between the ICache and DCache miss
// controllers: one request at a time, round-robin on contention, then the
// multi-beat write-data or read-response transfer for the owning cache.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned BEATS  = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              ic_req_valid,
  output logic              ic_req_ready,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_resp_valid,
  output logic [DATA_W-1:0] ic_resp_data,

  input  logic              dc_req_valid,
  output logic              dc_req_ready,
  input  logic              dc_req_rw,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic              dc_wdata_valid,
  output logic              dc_wdata_ready,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_resp_valid,
  output logic [DATA_W-1:0] dc_resp_data,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_wdata_valid,
  input  logic              mem_wdata_ready,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,

  output logic              grant,
  output logic              busy
);

  localparam int unsigned      CNT_W     = cnt_width(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;

  logic              arb_grant;
  logic [1:0]        arb_ready;
  logic              last_beat;
  logic [CNT_W-1:0]  cnt_next;

  mem_arbiter_rr_arb2 u_rr_arb2 (
    .valid      ({dc_req_valid, ic_req_valid}),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .ready      (arb_ready)
  );

  // Beat counter advance; wraps to zero on the final beat of a line
  assign last_beat = (cnt_q == LAST_BEAT);
  assign cnt_next  = last_beat ? '0 : cnt_q + CNT_W'(1);

  // State, owner and latched request registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= GRANT_IC;
      addr_q       <= '0;
      rw_q         <= RW_READ;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      rw_q         <= rw_d;
    end
  end

  // Next-state and handshake outputs; data paths are pure pass-through
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    last_grant_d    = last_grant_q;
    addr_d          = addr_q;
    rw_d            = rw_q;
    ic_req_ready    = 1'b0;
    dc_req_ready    = 1'b0;
    ic_resp_valid   = 1'b0;
    dc_resp_valid   = 1'b0;
    mem_req_valid   = 1'b0;
    mem_wdata_valid = 1'b0;
    dc_wdata_ready  = 1'b0;
    ic_resp_data    = mem_resp_data;
    dc_resp_data    = mem_resp_data;
    mem_wdata       = dc_wdata;

    case (state_q)
      ST_IDLE: begin
        // Ready is masked while reset is held so no handshake is advertised
        ic_req_ready = arb_ready[0] & reset;
        dc_req_ready = arb_ready[1] & reset;
        if (arb_ready != 2'b00) begin
          state_d      = ST_REQ;
          last_grant_d = arb_grant;
          addr_d       = (arb_grant == GRANT_DC) ? dc_req_addr : ic_req_addr;
          rw_d         = (arb_grant == GRANT_DC) ? dc_req_rw : RW_READ;
        end
      end

      ST_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = (rw_q == RW_WRITE) ? ST_WDATA : ST_RDATA;
        end
      end

      ST_WDATA: begin
        mem_wdata_valid = dc_wdata_valid;
        dc_wdata_ready  = mem_wdata_ready;
        if (dc_wdata_valid && mem_wdata_ready) begin
          cnt_d = cnt_next;
          if (last_beat) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_RDATA: begin
        if (last_grant_q == GRANT_DC) begin
          dc_resp_valid = mem_resp_valid;
        end else begin
          ic_resp_valid = mem_resp_valid;
        end
        if (mem_resp_valid) begin
          cnt_d = cnt_next;
          if (last_beat) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_req_addr = addr_q;
  assign mem_req_rw   = rw_q;
  assign grant        = last_grant_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, checked
// each cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned BEATS  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              ic_req_valid, ic_req_ready;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              ic_resp_valid;
  logic [DATA_W-1:0] ic_resp_data;
  logic              dc_req_valid, dc_req_ready, dc_req_rw;
  logic [ADDR_W-1:0] dc_req_addr;
  logic              dc_wdata_valid, dc_wdata_ready;
  logic [DATA_W-1:0] dc_wdata;
  logic              dc_resp_valid;
  logic [DATA_W-1:0] dc_resp_data;
  logic              mem_req_valid, mem_req_ready, mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_wdata_valid, mem_wdata_ready;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  logic              grant, busy;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
    .dc_req_addr(dc_req_addr), .dc_wdata_valid(dc_wdata_valid), .dc_wdata_ready(dc_wdata_ready),
    .dc_wdata(dc_wdata), .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_wdata_valid(mem_wdata_valid),
    .mem_wdata_ready(mem_wdata_ready), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Transaction-level model: who owns the port, what is outstanding
  bit                m_busy, m_pend, m_wr, m_last;
  logic [ADDR_W-1:0] m_addr;
  int                m_left;
  int                n_done = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_pend = 1'b0;
    m_wr   = 1'b0;
    m_last = 1'b0;
    m_addr = '0;
    m_left = 0;
  endtask

  task automatic idle_inputs();
    ic_req_valid    = 1'b0;
    ic_req_addr     = '0;
    dc_req_valid    = 1'b0;
    dc_req_rw       = 1'b0;
    dc_req_addr     = '0;
    dc_wdata_valid  = 1'b0;
    dc_wdata        = '0;
    mem_req_ready   = 1'b0;
    mem_wdata_ready = 1'b0;
    mem_resp_valid  = 1'b0;
    mem_resp_data   = '0;
  endtask

  // Called right after a falling edge with inputs applied: check outputs
  // against the model, advance the model across the rising edge, wait.
  task automatic step();
    logic e_icr, e_dcr, e_mrv, e_mwv, e_dwr, e_icv, e_dcv;
    #1;
    e_icr = 0; e_dcr = 0; e_mrv = 0; e_mwv = 0; e_dwr = 0; e_icv = 0; e_dcv = 0;
    if (!m_busy) begin
      e_icr = ic_req_valid && (!dc_req_valid || m_last);
      e_dcr = dc_req_valid && (!ic_req_valid || !m_last);
    end else if (m_pend) begin
      e_mrv = 1'b1;
    end else if (m_wr) begin
      e_mwv = dc_wdata_valid;
      e_dwr = mem_wdata_ready;
    end else begin
      e_icv = mem_resp_valid && !m_last;
      e_dcv = mem_resp_valid && m_last;
    end
    chk("ic_req_ready", 128'(ic_req_ready), 128'(e_icr));
    chk("dc_req_ready", 128'(dc_req_ready), 128'(e_dcr));
    chk("mem_req_valid", 128'(mem_req_valid), 128'(e_mrv));
    chk("mem_wdata_valid", 128'(mem_wdata_valid), 128'(e_mwv));
    chk("dc_wdata_ready", 128'(dc_wdata_ready), 128'(e_dwr));
    chk("ic_resp_valid", 128'(ic_resp_valid), 128'(e_icv));
    chk("dc_resp_valid", 128'(dc_resp_valid), 128'(e_dcv));
    chk("busy", 128'(busy), 128'(m_busy));
    chk("grant", 128'(grant), 128'(m_last));
    if (e_mrv) begin
      chk("mem_req_addr", 128'(mem_req_addr), 128'(m_addr));
      chk("mem_req_rw", 128'(mem_req_rw), 128'(m_wr));
    end
    if (e_mwv) chk("mem_wdata", 128'(mem_wdata), 128'(dc_wdata));
    if (e_icv) chk("ic_resp_data", 128'(ic_resp_data), 128'(mem_resp_data));
    if (e_dcv) chk("dc_resp_data", 128'(dc_resp_data), 128'(mem_resp_data));

    if (!m_busy) begin
      if (e_icr || e_dcr) begin
        m_last = e_dcr;
        m_addr = e_dcr ? dc_req_addr : ic_req_addr;
        m_wr   = e_dcr && dc_req_rw;
        m_busy = 1'b1;
        m_pend = 1'b1;
      end
    end else if (m_pend) begin
      if (mem_req_ready) begin
        m_pend = 1'b0;
        m_left = BEATS;
      end
    end else if ((m_wr && dc_wdata_valid && mem_wdata_ready) || (!m_wr && mem_resp_valid)) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        n_done++;
      end
    end
    @(negedge clk);
  endtask

  task automatic read_beats(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = (base < 0) ? rnd_data() : DATA_W'(base + i);
      step();
    end
    mem_resp_valid = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    chk(tag, 128'({ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid, mem_req_valid,
                   mem_wdata_valid, dc_wdata_ready, grant, busy, mem_req_rw}), 128'(0));
    chk({tag, "_addr"}, 128'(mem_req_addr), 128'(0));
  endtask

  int pat [6] = '{1, 0, 1, 1, 0, 1};

  initial begin
    reset = 1'b0;
    idle_inputs();
    ic_req_valid   = 1'b1;
    dc_req_valid   = 1'b1;
    mem_resp_valid = 1'b1;
    model_reset();
    #1;
    check_quiet("reset_outs");
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // ICache read alone, immediate mem_req_ready, beats 0xA..0xD
    ic_req_valid = 1'b1;
    ic_req_addr  = 28'h0000123;
    step();
    ic_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    step();
    chk("ic_addr_latched", 128'(mem_req_addr), 128'(28'h0000123));
    mem_req_ready = 1'b0;
    read_beats(BEATS, 'hA);
    chk("ic_read_done", 128'(busy), 128'(0));
    step();

    // Repeated ties: DCache first, then alternating
    for (int t = 0; t < 4; t++) begin
      ic_req_valid = 1'b1;
      ic_req_addr  = ADDR_W'($urandom);
      dc_req_valid = 1'b1;
      dc_req_rw    = 1'b0;
      dc_req_addr  = ADDR_W'($urandom);
      step();
      chk("tie_grant", 128'(grant), 128'((t % 2 == 0) ? 1 : 0));
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      read_beats(BEATS, -1);
    end
    idle_inputs();
    step();

    // DCache write with stuttering memory ready and spurious responses
    dc_req_valid   = 1'b1;
    dc_req_rw      = 1'b1;
    dc_req_addr    = 28'h0FFFFFF;
    mem_resp_valid = 1'b1;
    step();
    dc_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      dc_wdata_valid  = 1'b1;
      dc_wdata        = rnd_data();
      mem_wdata_ready = pat[i][0];
      mem_resp_data   = rnd_data();
      step();
    end
    chk("wr_done", 128'(busy), 128'(0));
    idle_inputs();
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;

    // Memory request stalled for five cycles while both caches wait
    ic_req_valid = 1'b1;
    ic_req_addr  = ADDR_W'($urandom);
    step();
    dc_req_valid = 1'b1;
    dc_req_addr  = ADDR_W'($urandom);
    for (int i = 0; i < 5; i++) step();
    mem_req_ready = 1'b1;
    ic_req_valid  = 1'b0;
    dc_req_valid  = 1'b0;
    step();
    mem_req_ready = 1'b0;
    read_beats(BEATS, -1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      ic_req_valid    = ($urandom_range(0, 3) == 0);
      ic_req_addr     = ADDR_W'($urandom);
      dc_req_valid    = ($urandom_range(0, 3) == 0);
      dc_req_rw       = 1'($urandom);
      dc_req_addr     = ADDR_W'($urandom);
      dc_wdata_valid  = 1'($urandom);
      dc_wdata        = rnd_data();
      mem_req_ready   = 1'($urandom);
      mem_wdata_ready = 1'($urandom);
      mem_resp_valid  = ($urandom_range(0, 4) != 0);
      mem_resp_data   = rnd_data();
      step();
    end
    chk("progress", 128'(n_done > 20), 128'(1));

    // Reset in the middle of a read after two beats
    idle_inputs();
    for (int i = 0; i < 2 * BEATS + 4 && m_busy; i++) begin
      dc_wdata_valid  = 1'b1;
      mem_wdata_ready = 1'b1;
      mem_req_ready   = 1'b1;
      mem_resp_valid  = 1'b1;
      step();
    end
    chk("drained", 128'(busy), 128'(0));
    idle_inputs();
    ic_req_valid = 1'b1;
    ic_req_addr  = ADDR_W'($urandom);
    step();
    ic_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    read_beats(2, -1);
    reset          = 1'b0;
    ic_req_valid   = 1'b1;
    mem_resp_valid = 1'b1;
    #1;
    check_quiet("mid_reset_outs");
    model_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    ic_req_valid = 1'b1;
    ic_req_addr  = 28'h0ABCDEF;
    step();
    ic_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    read_beats(BEATS, -1);
    chk("post_reset_done", 128'(busy), 128'(0));
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
